// File: rtl/fpu_pkg.sv
// Shared op codes, request record and constants for the FPU dispatch path.
package fpu_pkg;

    typedef enum logic [3:0] {
        OP_FADD  = 4'd2,
        OP_FSUB  = 4'd3,
        OP_FMUL  = 4'd4,
        OP_FINV  = 4'd5,
        OP_FDIV  = 4'd6,
        OP_FHALF = 4'd7,
        OP_FEQ   = 4'd11,
        OP_FLE   = 4'd12,
        OP_FABS  = 4'd13,
        OP_FNEG  = 4'd14
    } fpu_op_e;

    // Tag field width of a queued request; the dispatcher's TAG_W must not exceed it.
    localparam int FPU_TAG_W = 5;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic [3:0]           ctl;
        logic [31:0]          x1;
        logic [31:0]          x2;
        logic [FPU_TAG_W-1:0] tag;
    } fpu_req_t;

    function automatic logic is_legal_op(input logic [3:0] ctl);
        case (ctl)
            OP_FADD, OP_FSUB, OP_FMUL, OP_FINV, OP_FDIV,
            OP_FHALF, OP_FEQ, OP_FLE, OP_FABS, OP_FNEG: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO for the FPU dispatcher: DEPTH entries of fpu_req_t, registered count,
// no bypass of a same-cycle pop when full.
module fpu_req_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  fpu_req_t                wdata,
    output fpu_req_t                rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    fpu_req_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Queues FP ops from execute and issues them one at a time to the single-outstanding FPU.
// Optional macro FPU_TIMEOUT_EN: abandon an op that gets no fpu_ready within TIMEOUT cycles.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctl,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             fpu_en,
    output logic [3:0]       fpu_ctl,
    output logic [31:0]      fpu_x1,
    output logic [31:0]      fpu_x2,
    input  logic             fpu_ready,
    input  logic [31:0]      fpu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TAG_W > FPU_TAG_W) begin : g_bad_cfg
        $error("fpu_dispatch: DEPTH must be a power of two >= 2, TIMEOUT >= 1, TAG_W <= FPU_TAG_W");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_e;

    state_e                  state;
    state_e                  state_next;
    fpu_req_t                enq_req;
    fpu_req_t                head;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    pop;
    logic                    head_legal;
    logic                    timed_out;
    logic [TAG_W-1:0]        cur_tag;

    assign enq_req    = '{ctl: in_ctl, x1: in_x1, x2: in_x2, tag: FPU_TAG_W'(in_tag)};
    assign head_legal = is_legal_op(head.ctl);

    fpu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata (enq_req),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign in_ready  = !full;
    assign fpu_en    = (state == ISSUE);
    assign out_valid = (state == RESULT);
    assign busy      = (count != '0) || (state != IDLE);

`ifdef FPU_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] timer;

    assign timed_out = (state == WAIT) && !fpu_ready && (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (rst || state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT) begin
            timer <= timer + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pop happens from IDLE, or from RESULT on the writeback handshake, so a
    // queued op follows a retired one without passing through IDLE.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = head_legal ? ISSUE : RESULT;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (fpu_ready || timed_out) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = head_legal ? ISSUE : RESULT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Illegal ops never reach the FPU, so the issue registers keep the last legal op.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_ctl <= '0;
            fpu_x1  <= '0;
            fpu_x2  <= '0;
            cur_tag <= '0;
            out_y   <= '0;
            out_tag <= '0;
            out_err <= 1'b0;
        end else if (pop) begin
            if (head_legal) begin
                fpu_ctl <= head.ctl;
                fpu_x1  <= head.x1;
                fpu_x2  <= head.x2;
                cur_tag <= TAG_W'(head.tag);
            end else begin
                out_y   <= '0;
                out_tag <= TAG_W'(head.tag);
                out_err <= 1'b1;
            end
        end else if (state == WAIT && fpu_ready) begin
            out_y   <= fpu_y;
            out_tag <= cur_tag;
            out_err <= 1'b0;
        end else if (timed_out) begin
            out_y   <= QNAN;
            out_tag <= cur_tag;
            out_err <= 1'b1;
        end
    end

endmodule

// File: doc/fpu_dispatch.md
Name: fpu_dispatch

Overview:
Upstream feeder for the FPU wrapper, which has a single-outstanding `en`/`ready` protocol. It accepts FP ops from the core's execute stage into a small FIFO and issues them to the FPU one at a time. It holds `ctl`/`x1`/`x2` stable until `ready` and returns each result with its tag on a valid/ready port to writeback. This replaces the stall-until-ready loop the core would otherwise need.

Parameters:
DEPTH, 4, op FIFO entries (power of two, >=2)
TAG_W, 5, width of destination-register tag carried alongside each op
TIMEOUT, 64, cycles allowed between fpu_en and fpu_ready (used only with FPU_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  op offered by core
in_ready  out  1  FIFO not full
in_ctl  in  4  FPU op code
in_x1  in  32  operand 1 (IEEE single)
in_x2  in  32  operand 2
in_tag  in  TAG_W  destination tag
fpu_en  out  1  one-cycle issue pulse to FPU
fpu_ctl  out  4  op code to FPU, held until fpu_ready
fpu_x1  out  32  held operand 1
fpu_x2  out  32  held operand 2
fpu_ready  in  1  FPU result strobe, fpu_y valid this cycle
fpu_y  in  32  FPU result
out_valid  out  1  result available
out_ready  in  1  writeback accepts
out_y  out  32  result
out_tag  out  TAG_W  tag of result
out_err  out  1  op was illegal (or timed out, see option)
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values (synchronous, `rst`=1 at posedge):
  - FIFO emptied; FSM=IDLE.
  - `fpu_en`=0, `fpu_ctl`=0, `fpu_x1`=0, `fpu_x2`=0.
  - `out_valid`=0, `out_y`=0, `out_tag`=0, `out_err`=0, `busy`=0.
  - `in_ready`=1 from the first cycle after reset.
- Enqueue: on `in_valid && in_ready`. `in_ready`=!full, registered count, no same-cycle bypass of a pop.
- Legal ctl values: 2 fadd, 3 fsub, 4 fmul, 5 finv, 6 fdiv, 7 fhalf, 11 feq, 12 fle, 13 fabs, 14 fneg.
  - Any other code is enqueued normally.
  - It completes without touching the FPU: `out_y`=0, `out_err`=1.
- FSM states: IDLE, ISSUE, WAIT, RESULT.
  - IDLE: FIFO non-empty → pop head into the issue regs.
    - Legal ctl → ISSUE.
    - Illegal ctl → RESULT with err=1.
  - ISSUE: `fpu_en`=1 for exactly this cycle → WAIT.
  - WAIT: `fpu_en`=0; hold the issue regs. On `fpu_ready`: capture `fpu_y` and the tag, err=0 → RESULT.
  - RESULT: `out_valid`=1; `out_y`/`out_tag`/`out_err` stable. On `out_ready`:
    - FIFO non-empty → pop the next op and go straight to ISSUE (or RESULT if illegal).
    - Otherwise → IDLE.
- Latency: enqueue into an empty FIFO at cycle N gives `fpu_en` at N+2. The result is `out_valid` the cycle after `fpu_ready`.
- `fpu_ready` outside WAIT is ignored, including a stale strobe after reset mid-op.
- `fpu_ready` in the same cycle as ISSUE is ignored; the FPU cannot answer its own issue cycle.
- `fpu_ctl`/`fpu_x1`/`fpu_x2` change only on a pop. They keep their value after completion, because the FPU's result path may still sample `ctl` at `ready`.
- Simultaneous enqueue and pop with the FIFO full: the enqueue is refused (`in_ready`=0 that cycle).
- FIFO pointers are log2(DEPTH) bits, wrap naturally; the count is log2(DEPTH)+1 bits.
- Ordering: results return in strict enqueue order.

Optional Feature:
FPU_TIMEOUT_EN
- Defined:
  - A counter starts at ISSUE.
  - If it reaches TIMEOUT cycles in WAIT without `fpu_ready`, go to RESULT with `out_y`=32'h7FC00000 and `out_err`=1.
  - Any later `fpu_ready` is ignored until the next ISSUE.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Package `fpu_pkg`:
  - typedef enum logic[3:0] fpu_op_e with the codes listed above.
  - function is_legal_op.
  - typedef struct fpu_req_t {ctl, x1, x2, tag}.
  - localparam QNAN=32'h7FC00000.
- Sub-module `fpu_req_fifo`: parameterised DEPTH × fpu_req_t, synchronous reset, full/empty/count.
- The FSM stays in fpu_dispatch.

Test Plan:
- Behavioural FPU model, 3-cycle latency. Enqueue fadd x1=3F800000 x2=40000000 tag=5 → `fpu_en` exactly one cycle, `fpu_ctl`=2 held through `ready`; out_y=40400000, out_tag=5, out_err=0.
- Back-to-back enqueue of fmul (40000000×40400000, tag 1), fneg (3F800000, tag 2), feq (equal operands, tag 3) → results 40C00000, BF800000, 00000001 in tag order 1,2,3; `in_ready` falls after DEPTH=4 pending ops when the FPU latency is 20.
- Illegal ctl=9 with tag 7 → no `fpu_en`; out_y=0, out_err=1, tag 7; the following legal op still issues.
- `out_ready` held 0 for 10 cycles while in RESULT → out_* stable; no new `fpu_en` until the handshake; spurious `fpu_ready` pulses are ignored.
- Assert `rst` during WAIT, then the model fires `fpu_ready` one cycle later → no `out_valid`; busy=0; FIFO empty; next op behaves normally.
- FPU_TIMEOUT_EN, model never responds, TIMEOUT=64 → `out_valid` 65 cycles after ISSUE with out_y=7FC00000, out_err=1.
